// File: rtl/addsub_rr_scheduler.sv
// Round-robin scheduler sharing one n-bit add/subtract unit between two requesters,
// with a private accumulator per requester and an id-tagged response channel.
module addsub_rr_scheduler #(
  parameter int unsigned n = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [n-1:0] req0_a,
  input  logic [n-1:0] req0_b,
  input  logic         req0_addsub,
  input  logic         req0_acc,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [n-1:0] req1_a,
  input  logic [n-1:0] req1_b,
  input  logic         req1_addsub,
  input  logic         req1_acc,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [n-1:0] rsp_z,
  output logic         rsp_ovf,
  output logic         rsp_cout,
  input  logic [1:0]   acc_clr,
  output logic [n-1:0] acc0,
  output logic [n-1:0] acc1,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e r_state, w_state_next;

  logic         r_last;
  logic [n-1:0] r_a, r_b;
  logic         r_addsub, r_acc_sel, r_id;
  logic         r_rsp_valid, r_rsp_id, r_rsp_ovf, r_rsp_cout;
  logic [n-1:0] r_rsp_z, r_acc0, r_acc1;

  logic         w_any, w_grant, w_accept, w_exec;
  logic [n-1:0] w_g, w_h, w_m;
  logic [n:0]   w_sum;
  logic         w_ovf;

  // On contention the requester not served last wins.
  assign w_any   = req0_valid | req1_valid;
  assign w_grant = (req0_valid & req1_valid) ? ~r_last : req1_valid;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StExec;
      StExec:  w_state_next = StResp;
      StResp:  if (rsp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    req0_ready = (r_state == StIdle) & ~Reset & req0_valid & ~w_grant;
    req1_ready = (r_state == StIdle) & ~Reset & req1_valid & w_grant;
    w_accept   = (r_state == StIdle) & w_any;
    w_exec     = (r_state == StExec);
    busy       = (r_state != StIdle);
  end

  assign w_g   = r_acc_sel ? (r_id ? r_acc1 : r_acc0) : r_a;
  assign w_h   = r_addsub ? ~r_b : r_b;
  assign w_sum = {1'b0, w_g} + {1'b0, w_h} + {{n{1'b0}}, r_addsub};
  assign w_m   = w_sum[n-1:0];
  assign w_ovf = (w_g[n-1] & w_h[n-1] & ~w_m[n-1]) | (~w_g[n-1] & ~w_h[n-1] & w_m[n-1]);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_last      <= 1'b1;
      r_a         <= '0;
      r_b         <= '0;
      r_addsub    <= 1'b0;
      r_acc_sel   <= 1'b0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_z     <= '0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_cout  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a       <= w_grant ? req1_a : req0_a;
        r_b       <= w_grant ? req1_b : req0_b;
        r_addsub  <= w_grant ? req1_addsub : req0_addsub;
        r_acc_sel <= w_grant ? req1_acc : req0_acc;
        r_id      <= w_grant;
        r_last    <= w_grant;
      end
      if (w_exec) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_id;
        r_rsp_z     <= w_m;
        r_rsp_ovf   <= w_ovf;
        r_rsp_cout  <= w_sum[n];
      end else if ((r_state == StResp) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // A synchronous clear beats the EXEC write-back to the same accumulator.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_acc0 <= '0;
      r_acc1 <= '0;
    end else begin
      if (acc_clr[0])              r_acc0 <= '0;
      else if (w_exec && !r_id)    r_acc0 <= w_m;
      if (acc_clr[1])              r_acc1 <= '0;
      else if (w_exec && r_id)     r_acc1 <= w_m;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_z     = r_rsp_z;
  assign rsp_ovf   = r_rsp_ovf;
  assign rsp_cout  = r_rsp_cout;
  assign acc0      = r_acc0;
  assign acc1      = r_acc1;

endmodule

// File: doc/addsub_rr_scheduler.md
Name: addsub_rr_scheduler

Overview:
Round-robin scheduler that shares one n-bit two's-complement add/subtract unit between two requesters. Each requester issues operations through a valid/ready handshake. Each operation uses either its own operand A or that requester's private accumulator as the X operand. Results return on a single response channel tagged with the requester ID. The block sits between the switch/key input logic, or any two command sources, and the LED/result consumers.

Parameters:
n, 8, datapath width in bits for operands, result and accumulators.

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle when valid&ready
req0_a  input  n  X operand when req0_acc=0
req0_b  input  n  Y operand
req0_addsub  input  1  0 = add, 1 = subtract (X - Y)
req0_acc  input  1  1 = use accumulator 0 as X instead of req0_a
req1_valid, req1_ready, req1_a, req1_b, req1_addsub, req1_acc: same as requester 0, for requester 1
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_id  output  1  requester that issued the operation
rsp_z  output  n  result
rsp_ovf  output  1  signed overflow
rsp_cout  output  1  adder carry-out
acc_clr  input  2  synchronous clear of accumulator i (bit i)
acc0, acc1  output  n  current accumulator contents
busy  output  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE, rsp_valid=0, rsp_id=0, rsp_z=0, rsp_ovf=0, rsp_cout=0, acc0=acc1=0, last_served=1 (requester 0 wins the first contention), all readies 0 combinationally in the reset state.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = requester with valid; if both are valid, grant the one != last_served.
  - reqX_ready = (state==IDLE) & (grant==X); at most one ready is high.
  - On accept: capture a, b, addsub, acc and the id into internal registers; last_served <= id; go to EXEC.
  - With no valid, stay in IDLE.
- EXEC (exactly 1 cycle):
  - G = acc_sel ? acc[id] : a.
  - H = addsub ? ~b : b.
  - {cout, M} = G + H + addsub, computed at n+1 bits.
  - ovf = (G[n-1]&H[n-1]&~M[n-1]) | (~G[n-1]&~H[n-1]&M[n-1]).
  - Register rsp_z=M, rsp_ovf, rsp_cout and rsp_id; rsp_valid<=1.
  - acc[id] <= M on every operation, whether or not acc_sel is set.
  - Go to RESP.
- RESP:
  - Response outputs are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: rsp_valid<=0, go to IDLE. rsp_z, rsp_id, rsp_ovf and rsp_cout keep their last values.
- Latency: accept edge -> rsp_valid high 2 rising edges later. Maximum throughput is one op per 3 cycles with rsp_ready tied high.
- acc_clr[i]: acc_i <= 0 on the next edge. If it coincides with an EXEC write to the same accumulator, the clear wins. The rsp_z for that operation still shows M.
- acc_clr has no effect on the FSM or on the response registers.
- A requester dropping valid before ready is permitted; the grant is re-evaluated each IDLE cycle.
- Payload is sampled only on the accept edge; later changes do not affect an in-flight op.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded and all state returns to the reset values; no response is produced.
- Arithmetic wraps modulo 2^n; overflow is flagged only and never saturates.

Test Plan:
1. n=8, req0 a=0x05 b=0x03 addsub=0 acc=0 -> req0_ready high in IDLE; 2 edges after accept: rsp_valid=1, rsp_id=0, rsp_z=0x08, ovf=0, cout=0, acc0=0x08.
2. req0 a=0x10 b=0x01 addsub=1 -> rsp_z=0x0F, cout=1, ovf=0. Then a=0x7F b=0x01 add -> rsp_z=0x80, ovf=1. Then a=0x80 b=0x01 sub -> rsp_z=0x7F, ovf=1.
3. Both valid continuously after reset, rsp_ready=1 -> accepts ordered 0,1,0,1; each rsp_id matches; never both readies high in one cycle.
4. req1 acc=1 b=0x02 add, issued 3 times from reset -> rsp_z 0x02, 0x04, 0x06; acc1=0x06, acc0=0x00. Then acc_clr=2'b10 during the EXEC of a 4th op -> rsp_z=0x08, acc1=0x00.
5. rsp_ready low 3 cycles in RESP -> rsp_valid/rsp_z/rsp_id stable, req0_ready=req1_ready=0, busy=1. rsp_ready high -> IDLE the next cycle.
6. Assert Reset during EXEC, then during RESP -> immediately rsp_valid=0, acc0=acc1=0, busy=0; after release, the first contention grants requester 0.
